mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous word memory between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write with byte mask).
- Sits between the pipeline fetch/MEM stages and the memory array.
- Grants one access per cycle and returns read data one cycle after grant.
- D has priority; a starvation counter bounds how long I can be locked out.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals shared by the fetch/load-store memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_wen;
  logic [31:0]       d_req_wdata;
  logic [3:0]        d_req_mask;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;

  logic [ADDR_W-3:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_mask,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
    input  mem_rdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_mask,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between fetch (I) and load/store (D); D wins, I is forced after STARVE_LIMIT losses.
// Define MEM_ARB_STATS_EN to add the stat_i_stall / stat_d_grant / stat_force counters.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_i_stall,
  output logic [31:0]       stat_d_grant,
  output logic [15:0]       stat_force
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } respTag_t;

  respTag_t   respTag_r;
  respTag_t   respTagNext_s;
  logic [3:0] starveCnt_r;
  logic [3:0] starveCntNext_s;
  logic       grantI_s;
  logic       grantD_s;
  logic       forceI_s;
  logic       unusedAddrBits_s;

  // Byte offset within the word plays no part in a word-wide access.
  assign unusedAddrBits_s = ^{bus.i_req_addr[1:0], bus.d_req_addr[1:0]};

  // Grant selection: D first, I forced once its starvation count reaches the limit.
  always_comb begin
    grantI_s = 1'b0;
    grantD_s = 1'b0;
    forceI_s = 1'b0;
    if (rst) begin
      grantI_s = 1'b0;
      grantD_s = 1'b0;
    end else if (bus.i_req_valid && bus.d_req_valid) begin
      if (starveCnt_r == LIMIT) begin
        grantI_s = 1'b1;
        forceI_s = 1'b1;
      end else begin
        grantD_s = 1'b1;
      end
    end else if (bus.i_req_valid) begin
      grantI_s = 1'b1;
    end else if (bus.d_req_valid) begin
      grantD_s = 1'b1;
    end else begin
      grantI_s = 1'b0;
      grantD_s = 1'b0;
    end
  end

  assign bus.i_req_ready = grantI_s;
  assign bus.d_req_ready = grantD_s;

  // Memory command for the granted requester; an idle cycle parks the address at zero.
  always_comb begin
    bus.mem_addr  = {(ADDR_W-2){1'b0}};
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = 32'd0;
    bus.mem_mask  = 4'd0;
    case ({grantI_s, grantD_s})
      2'b10: begin
        bus.mem_addr = bus.i_req_addr[ADDR_W-1:2];
        bus.mem_ren  = 1'b1;
      end
      2'b01: begin
        bus.mem_addr = bus.d_req_addr[ADDR_W-1:2];
        if (bus.d_req_wen) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = bus.d_req_wdata;
          bus.mem_mask  = bus.d_req_mask;
        end else begin
          bus.mem_ren   = 1'b1;
        end
      end
      default: begin
        bus.mem_addr  = {(ADDR_W-2){1'b0}};
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
      end
    endcase
  end

  // Starvation count: D wins while I waits; any I grant or idle I clears it.
  always_comb begin
    starveCntNext_s = starveCnt_r;
    if (!bus.i_req_valid || grantI_s) begin
      starveCntNext_s = 4'd0;
    end else if (grantD_s && (starveCnt_r != LIMIT)) begin
      starveCntNext_s = starveCnt_r + 4'd1;
    end else begin
      starveCntNext_s = starveCnt_r;
    end
  end

  // Starvation count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt_r <= 4'd0;
    end else begin
      starveCnt_r <= starveCntNext_s;
    end
  end

  // Next response owner: the read granted this cycle, writes answer nobody.
  always_comb begin
    respTagNext_s = TAG_NONE;
    if (grantI_s) begin
      respTagNext_s = TAG_I;
    end else if (grantD_s && !bus.d_req_wen) begin
      respTagNext_s = TAG_D;
    end else begin
      respTagNext_s = TAG_NONE;
    end
  end

  // Response owner register.
  always_ff @(posedge clk) begin
    if (rst) begin
      respTag_r <= TAG_NONE;
    end else begin
      respTag_r <= respTagNext_s;
    end
  end

  // Response strobes; reset suppresses a read accepted just before it.
  always_comb begin
    bus.i_resp_valid = 1'b0;
    bus.d_resp_valid = 1'b0;
    if (rst) begin
      bus.i_resp_valid = 1'b0;
      bus.d_resp_valid = 1'b0;
    end else begin
      case (respTag_r)
        TAG_I:   bus.i_resp_valid = 1'b1;
        TAG_D:   bus.d_resp_valid = 1'b1;
        default: begin
          bus.i_resp_valid = 1'b0;
          bus.d_resp_valid = 1'b0;
        end
      endcase
    end
  end

  assign bus.i_resp_data = bus.mem_rdata;
  assign bus.d_resp_data = bus.mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] statIStall_r;
  logic [31:0] statDGrant_r;
  logic [15:0] statForce_r;

  // Free-running event counters, wrapping at full width.
  always_ff @(posedge clk) begin
    if (rst) begin
      statIStall_r <= 32'd0;
      statDGrant_r <= 32'd0;
      statForce_r  <= 16'd0;
    end else begin
      if (bus.i_req_valid && !grantI_s) begin
        statIStall_r <= statIStall_r + 32'd1;
      end
      if (grantD_s) begin
        statDGrant_r <= statDGrant_r + 32'd1;
      end
      if (forceI_s) begin
        statForce_r <= statForce_r + 16'd1;
      end
    end
  end

  assign stat_i_stall = statIStall_r;
  assign stat_d_grant = statDGrant_r;
  assign stat_force   = statForce_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a behavioural model and a word memory.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int ADDR_W       = 32;
  localparam int NWORDS       = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] statIStall;
  logic [31:0] statDGrant;
  logic [15:0] statForce;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_stall(statIStall),
    .stat_d_grant(statDGrant),
    .stat_force(statForce)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] refMem [NWORDS];
  logic [31:0] envMem [NWORDS];
  int          mStarve;
  int          mTag;      // 0 none, 1 fetch, 2 load
  logic [31:0] mData;
  int          mStall;
  int          mDGrant;
  int          mForce;

  bit          accI, accD;
  bit          obsIV, obsDV;
  logic [31:0] obsIData, obsDData;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check the cycle at the falling edge, advance model and memory at the rising edge.
  task automatic tick();
    bit          atLim, expI, expD, dWr;
    int          iw, dw;
    logic [ADDR_W-3:0] expAddr;
    bit          eWen, eRen;
    logic [5:0]  eIdx;
    logic [31:0] eWdata;
    logic [3:0]  eMask;
    @(negedge clk);
    atLim = (mStarve == STARVE_LIMIT);
    expI  = !rst && bus.i_req_valid && (!bus.d_req_valid || atLim);
    expD  = !rst && bus.d_req_valid && !(bus.i_req_valid && atLim);
    dWr   = expD && bus.d_req_wen;
    iw    = int'(bus.i_req_addr[7:2]);
    dw    = int'(bus.d_req_addr[7:2]);
    expAddr = expI ? bus.i_req_addr[ADDR_W-1:2] : (expD ? bus.d_req_addr[ADDR_W-1:2] : '0);

    check("i_req_ready", 64'(bus.i_req_ready), 64'(expI));
    check("d_req_ready", 64'(bus.d_req_ready), 64'(expD));
    check("mem_ren", 64'(bus.mem_ren), 64'(expI || (expD && !bus.d_req_wen)));
    check("mem_wen", 64'(bus.mem_wen), 64'(dWr));
    check("mem_addr", 64'(bus.mem_addr), 64'(expAddr));
    if (dWr) begin
      check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.d_req_wdata));
      check("mem_mask", 64'(bus.mem_mask), 64'(bus.d_req_mask));
    end else if (expI || expD) begin
      check("mem_mask_rd", 64'(bus.mem_mask), 64'd0);
    end
    check("i_resp_valid", 64'(bus.i_resp_valid), 64'(!rst && mTag == 1));
    check("d_resp_valid", 64'(bus.d_resp_valid), 64'(!rst && mTag == 2));
    if (!rst && mTag == 1) check("i_resp_data", 64'(bus.i_resp_data), 64'(mData));
    if (!rst && mTag == 2) check("d_resp_data", 64'(bus.d_resp_data), 64'(mData));

    obsIV = bus.i_resp_valid;  obsIData = bus.i_resp_data;
    obsDV = bus.d_resp_valid;  obsDData = bus.d_resp_data;
    accI  = expI;
    accD  = expD;

    if (rst) begin
      mStarve = 0; mTag = 0; mStall = 0; mDGrant = 0; mForce = 0;
    end else begin
      if (dWr) refMem[dw] = mergeBytes(refMem[dw], bus.d_req_wdata, bus.d_req_mask);
      mTag  = expI ? 1 : ((expD && !bus.d_req_wen) ? 2 : 0);
      mData = expI ? refMem[iw] : refMem[dw];
      if (!bus.i_req_valid || expI) mStarve = 0;
      else if (expD && mStarve < STARVE_LIMIT) mStarve++;
      if (bus.i_req_valid && !expI) mStall++;
      if (expD) mDGrant++;
      if (expI && bus.d_req_valid) mForce++;
    end

    eWen = bus.mem_wen; eRen = bus.mem_ren; eIdx = bus.mem_addr[5:0];
    eWdata = bus.mem_wdata; eMask = bus.mem_mask;
    @(posedge clk);
    if (eWen) envMem[eIdx] = mergeBytes(envMem[eIdx], eWdata, eMask);
    if (eRen) bus.mem_rdata = envMem[eIdx];
    #1;
  endtask

  task automatic idle();
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
  endtask

  task automatic setI(input logic [31:0] a);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
  endtask

  task automatic setD(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] m);
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = a;
    bus.d_req_wen   = w;
    bus.d_req_wdata = wd;
    bus.d_req_mask  = m;
  endtask

  initial begin
    bit iPend, dPend;
    logic [31:0] w;
    rst = 1'b1;
    idle();
    bus.i_req_addr = 32'd0;
    setD(32'd0, 1'b0, 32'd0, 4'd0);
    bus.d_req_valid = 1'b0;
    bus.mem_rdata = 32'd0;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom;
      refMem[i] = w;
      envMem[i] = w;
    end
    mStarve = 0; mTag = 0; mData = 32'd0; mStall = 0; mDGrant = 0; mForce = 0;

    // Reset holds both readies low even with requests present.
    tick();
    setI(32'h0000_0004);
    setD(32'h0000_0008, 1'b0, 32'd0, 4'd0);
    tick();
    check("rst_i_ready", 64'(accI), 64'd0);
    check("rst_d_ready", 64'(accD), 64'd0);
    rst = 1'b0;
    idle();
    tick();

    // Fetch-only read.
    refMem[4] = 32'hDEAD_BEEF;
    envMem[4] = 32'hDEAD_BEEF;
    setI(32'h0000_0010);
    tick();
    check("iread_accept", 64'(accI), 64'd1);
    idle();
    tick();
    check("iread_resp_valid", 64'(obsIV), 64'd1);
    check("iread_resp_data", 64'(obsIData), 64'hDEAD_BEEF);

    // Masked write followed by a read of the same word.
    refMem[8] = 32'hAAAA_AAAA;
    envMem[8] = 32'hAAAA_AAAA;
    setD(32'h0000_0020, 1'b1, 32'h1122_3344, 4'b0011);
    tick();
    check("dwrite_accept", 64'(accD), 64'd1);
    setD(32'h0000_0020, 1'b0, 32'd0, 4'd0);
    tick();
    check("dread_accept", 64'(accD), 64'd1);
    idle();
    tick();
    check("dread_resp_valid", 64'(obsDV), 64'd1);
    check("dread_resp_data", 64'(obsDData), 64'hAAAA_3344);

    // Continuous contention from a clean starvation count: D,D,D,D,I repeating.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setI(32'h0000_0040);
    setD(32'h0000_0044, 1'b0, 32'd0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("cont_grant_i", 64'(accI), 64'(k % 5 == 4));
      check("cont_grant_d", 64'(accD), 64'(k % 5 != 4));
    end
`ifdef MEM_ARB_STATS_EN
    check("stat_force", 64'(statForce), 64'd2);
    check("stat_d_grant", 64'(statDGrant), 64'd8);
    check("stat_i_stall", 64'(statIStall), 64'd8);
`endif
    idle();
    tick();

    // Continuous D with I idle: D every cycle, no fetch response.
    for (int k = 0; k < 6; k++) begin
      setD(32'(4 * k), 1'(k % 2), $urandom, 4'hF);
      tick();
      check("idlei_grant_d", 64'(accD), 64'd1);
      check("idlei_no_iresp", 64'(obsIV), 64'd0);
    end
    idle();
    tick();

    // Reset right after a fetch is accepted: no fetch response ever appears.
    setI(32'h0000_0010);
    tick();
    check("rstmid_accept", 64'(accI), 64'd1);
    rst = 1'b1;
    setD(32'h0000_0010, 1'b0, 32'd0, 4'd0);
    tick();
    check("rstmid_resp_c1", 64'(obsIV), 64'd0);
    check("rstmid_i_ready", 64'(accI), 64'd0);
    check("rstmid_d_ready", 64'(accD), 64'd0);
    rst = 1'b0;
    idle();
    tick();
    check("rstmid_resp_c2", 64'(obsIV), 64'd0);

    // Random traffic; requests hold their fields until accepted.
    iPend = 1'b0;
    dPend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!iPend && $urandom_range(0, 3) != 0) begin
        iPend = 1'b1;
        bus.i_req_addr = {24'd0, 8'($urandom)};
      end
      if (!dPend && $urandom_range(0, 7) != 0) begin
        dPend = 1'b1;
        setD({24'd0, 8'($urandom)}, 1'($urandom), $urandom, 4'($urandom));
      end
      bus.i_req_valid = iPend;
      bus.d_req_valid = dPend;
      tick();
      if (accI) iPend = 1'b0;
      if (accD) dPend = 1'b0;
    end
    rst = 1'b0;
    idle();
    tick();
`ifdef MEM_ARB_STATS_EN
    check("rand_stat_i_stall", 64'(statIStall), 64'(mStall));
    check("rand_stat_d_grant", 64'(statDGrant), 64'(mDGrant));
    check("rand_stat_force", 64'(statForce), 64'(16'(mForce)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
